// File: rtl/prog_load_pkg.sv
// prog_load_pkg: FSM state encoding and default framing bytes; CSUM state exists only with PROG_LOAD_CSUM_EN
package prog_load_pkg;
    localparam logic [7:0] START_BYTE_DEF = 8'hFE;
    localparam logic [7:0] END_BYTE_DEF   = 8'hFF;
    localparam logic [7:0] ESC_BYTE_DEF   = 8'hFD;
`ifdef PROG_LOAD_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ESC, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ESC, S_DONE} state_t;
`endif
endpackage

// File: rtl/prog_load_ctrl_if.sv
// prog_load_ctrl_if: serial byte input, instruction-memory write port and load status
interface prog_load_ctrl_if #(parameter int ADDR_W = 6);
    logic              byte_valid_i;
    logic [7:0]        byte_data_i;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_waddr_o;
    logic [31:0]       imem_wdata_o;
    logic              cpu_hold_o;
    logic              load_done_o;
    logic              load_err_o;
    logic [ADDR_W:0]   word_count_o;
    modport master (
        output byte_valid_i, byte_data_i,
        input  byte_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o,
        input  cpu_hold_o, load_done_o, load_err_o, word_count_o
    );
    modport slave (
        input  byte_valid_i, byte_data_i,
        output byte_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o,
        output cpu_hold_o, load_done_o, load_err_o, word_count_o
    );
endinterface

// File: rtl/prog_load_packer.sv
// prog_load_packer: big-endian byte-to-word packer with zero-padded flush of partial words
module prog_load_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic        flush_i,
    input  logic [7:0]  din_i,
    output logic        fire_o,
    output logic        we_o,
    output logic [31:0] wdata_o
);
    logic [1:0]  lane_q, lane_d;
    logic [31:0] sr_q, sr_d, wdata_q, wdata_d, merged;
    logic        we_q;
    assign fire_o  = (push_i && lane_q == 2'd3) || (flush_i && lane_q != 2'd0);
    assign we_o    = we_q;
    assign wdata_o = wdata_q;
    // Insert the incoming byte into its lane; a fresh word starts from zero so unfilled bytes pad as 0
    always_comb begin
        merged = (lane_q == 2'd0) ? 32'd0 : sr_q;
        merged[{~lane_q, 3'b000} +: 8] = din_i;
        lane_d  = (clr_i || flush_i) ? 2'd0 : push_i ? lane_q + 2'd1 : lane_q;
        sr_d    = (clr_i || flush_i) ? 32'd0 : push_i ? merged : sr_q;
        wdata_d = fire_o ? (push_i ? merged : sr_q) : wdata_q;
    end
    // Lane/shift state and the one-cycle registered write strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q  <= 2'd0;
            sr_q    <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
        end else begin
            lane_q  <= lane_d;
            sr_q    <= sr_d;
            we_q    <= fire_o;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: framed serial program loader into instruction memory; PROG_LOAD_CSUM_EN adds an XOR checksum byte
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int         ADDR_W     = 6,
    parameter logic [7:0] START_BYTE = START_BYTE_DEF,
    parameter logic [7:0] END_BYTE   = END_BYTE_DEF,
    parameter logic [7:0] ESC_BYTE   = ESC_BYTE_DEF
) (
    input logic             clk,
    input logic             reset,
    prog_load_ctrl_if.slave bus
);
    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              err_q, err_d;
    logic              ready, acc, clr, take, push, flush, fire;
    logic [7:0]        b;
`ifdef PROG_LOAD_CSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              csum_bad;
`endif
    assign b     = bus.byte_data_i;
    assign ready = state_q != S_DONE;
    assign acc   = bus.byte_valid_i && ready;
    assign push  = take && !cnt_q[ADDR_W];
    assign bus.byte_ready_o = ready;
    assign bus.cpu_hold_o   = state_q != S_IDLE;
    assign bus.load_done_o  = state_q == S_DONE && !err_q;
    assign bus.load_err_o   = err_q;
    assign bus.word_count_o = cnt_q;
    assign bus.imem_waddr_o = waddr_q;
    prog_load_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr),
        .push_i  (push),
        .flush_i (flush),
        .din_i   (b),
        .fire_o  (fire),
        .we_o    (bus.imem_we_o),
        .wdata_o (bus.imem_wdata_o)
    );
    // Framing FSM: decode each accepted byte into restart/escape/end/data requests
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        take    = 1'b0;
        flush   = 1'b0;
`ifdef PROG_LOAD_CSUM_EN
        csum_bad = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (acc && b == START_BYTE) begin
                clr     = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: if (acc) begin
                if (b == START_BYTE) clr = 1'b1;
                else if (b == ESC_BYTE) state_d = S_ESC;
                else if (b == END_BYTE) begin
                    flush = 1'b1;
`ifdef PROG_LOAD_CSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else take = 1'b1;
            end
            S_ESC: if (acc) begin
                take    = 1'b1;
                state_d = S_LOAD;
            end
`ifdef PROG_LOAD_CSUM_EN
            S_CSUM: if (acc) begin
                csum_bad = b != csum_q;
                state_d  = S_DONE;
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    // Word counter, write address and error tracking; data past a full memory is dropped and flagged
    always_comb begin
        cnt_d   = fire ? cnt_q + 1'b1 : cnt_q;
        waddr_d = fire ? cnt_q[ADDR_W-1:0] : waddr_q;
        err_d   = err_q || (take && cnt_q[ADDR_W]);
`ifdef PROG_LOAD_CSUM_EN
        err_d  = err_d || csum_bad;
        csum_d = clr ? 8'd0 : push ? csum_q ^ b : csum_q;
`endif
        if (clr) begin
            cnt_d   = '0;
            waddr_d = '0;
            err_d   = 1'b0;
        end
    end
    // State and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            err_q   <= 1'b0;
`ifdef PROG_LOAD_CSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            err_q   <= err_d;
`ifdef PROG_LOAD_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed byte streams with a write/completion scoreboard
module tb_prog_load_ctrl;
    localparam int AW = 2;
`ifdef PROG_LOAD_CSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    typedef struct {
        bit            is_end;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        bit            in_done;
        bit            done;
        bit            err;
        logic [AW:0]   cnt;
    } exp_t;
    typedef logic [7:0] bytes_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    prog_load_ctrl_if #(.ADDR_W(AW)) bus();
    prog_load_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] d, input bit in_done);
        exp_t e;
        e.is_end = 1'b0; e.addr = a; e.data = d; e.in_done = in_done;
        e.done = 1'b0; e.err = 1'b0; e.cnt = '0;
        q.push_back(e);
    endtask

    task automatic exp_end(input bit done, input bit err, input logic [AW:0] cnt);
        exp_t e;
        e.is_end = 1'b1; e.addr = '0; e.data = '0; e.in_done = 1'b1;
        e.done = done; e.err = err; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        while (!bus.byte_ready_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready_o) begin
            miscompares++;
            $display("FAIL ready_timeout: byte %h not accepted within 8 cycles", b);
        end
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic send_all(input bytes_t v);
        foreach (v[i]) send(v[i]);
    endtask

    task automatic load(input bytes_t v, input logic [7:0] cs);
        send_all(v);
        if (CS) send(cs);
        @(negedge clk);
        chk("hold_after_done", 32'(bus.cpu_hold_o), 32'(0));
        chk("queue_drained", 32'(q.size()), 32'(0));
    endtask

    // Monitor: every write strobe and every DONE cycle pops and checks the next expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.load_done_o && bus.byte_ready_o) begin
                    miscompares++;
                    $display("FAIL done_outside_done: load_done_o=1 while ready, required 0");
                end
                if (bus.imem_we_o) begin
                    if (q.size() == 0 || q[0].is_end) begin
                        miscompares++;
                        $display("FAIL write_unexpected: addr %0h data %h, no write required", bus.imem_waddr_o, bus.imem_wdata_o);
                    end else begin
                        e = q.pop_front();
                        chk("write_addr", 32'(bus.imem_waddr_o), 32'(e.addr));
                        chk("write_data", bus.imem_wdata_o, e.data);
                        chk("write_in_done_cycle", 32'(!bus.byte_ready_o), 32'(e.in_done));
                    end
                end
                if (!bus.byte_ready_o) begin
                    if (q.size() == 0 || !q[0].is_end) begin
                        miscompares++;
                        $display("FAIL done_unexpected: DONE state reached, pending write or nothing required");
                    end else begin
                        e = q.pop_front();
                        chk("load_done", 32'(bus.load_done_o), 32'(e.done));
                        chk("load_err", 32'(bus.load_err_o), 32'(e.err));
                        chk("word_count", 32'(bus.word_count_o), 32'(e.cnt));
                        chk("hold_in_done", 32'(bus.cpu_hold_o), 32'(1));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        bytes_t v;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(bus.imem_we_o), 32'(0));
        chk("rst_hold", 32'(bus.cpu_hold_o), 32'(0));
        chk("rst_count", 32'(bus.word_count_o), 32'(0));
        chk("rst_err", 32'(bus.load_err_o), 32'(0));
        chk("rst_ready", 32'(bus.byte_ready_o), 32'(1));
        reset = 1'b0;
        @(negedge clk);
        v = {8'h12, 8'hFF, 8'hFD, 8'h00};
        send_all(v);
        chk("idle_discard_hold", 32'(bus.cpu_hold_o), 32'(0));

        exp_wr(2'd0, 32'h00000013, 1'b0); exp_end(1'b1, 1'b0, 3'd1);
        v = {8'hFE, 8'h00, 8'h00, 8'h00, 8'h13, 8'hFF};
        load(v, 8'h13);

        exp_wr(2'd0, 32'hFFFE0102, 1'b0); exp_end(1'b1, 1'b0, 3'd1);
        v = {8'hFE, 8'hFD, 8'hFF, 8'hFD, 8'hFE, 8'h01, 8'h02, 8'hFF};
        load(v, 8'h02);

        exp_wr(2'd0, 32'hAABB0000, !CS); exp_end(1'b1, 1'b0, 3'd1);
        v = {8'hFE, 8'hAA, 8'hBB, 8'hFF};
        load(v, 8'h11);

        exp_end(1'b1, 1'b0, 3'd0);
        v = {8'hFE, 8'hFF};
        load(v, 8'h00);

        exp_wr(2'd0, 32'h03040506, 1'b0); exp_end(1'b1, 1'b0, 3'd1);
        v = {8'hFE, 8'h01, 8'h02, 8'hFE, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF};
        load(v, 8'h04);

        exp_wr(2'd0, 32'h01020304, 1'b0);
        exp_wr(2'd1, 32'h05060708, 1'b0);
        exp_wr(2'd2, 32'h090A0B0C, 1'b0);
        exp_wr(2'd3, 32'h0D0E0F10, 1'b0);
        exp_end(1'b0, 1'b1, 3'd4);
        v = {8'hFE};
        for (int i = 1; i <= 17; i++) v.push_back(8'(i));
        v.push_back(8'hFF);
        load(v, 8'h10);
        chk("err_sticky", 32'(bus.load_err_o), 32'(1));
        chk("count_hold_after_overflow", 32'(bus.word_count_o), 32'(4));

        exp_wr(2'd0, 32'h01020304, 1'b0);
        v = {8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22};
        send_all(v);
        chk("pre_reset_count", 32'(bus.word_count_o), 32'(1));
        chk("pre_reset_hold", 32'(bus.cpu_hold_o), 32'(1));
        #1 reset = 1'b1;
        #1;
        chk("midload_rst_hold", 32'(bus.cpu_hold_o), 32'(0));
        chk("midload_rst_count", 32'(bus.word_count_o), 32'(0));
        chk("midload_rst_we", 32'(bus.imem_we_o), 32'(0));
        chk("midload_rst_done", 32'(bus.load_done_o), 32'(0));
        chk("midload_rst_err", 32'(bus.load_err_o), 32'(0));
        chk("midload_rst_ready", 32'(bus.byte_ready_o), 32'(1));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_wr(2'd0, 32'h01020304, 1'b0); exp_end(1'b1, 1'b0, 3'd1);
        v = {8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        load(v, 8'h04);

        if (CS) begin
            exp_wr(2'd0, 32'h01020304, 1'b0); exp_end(1'b0, 1'b1, 3'd1);
            load(v, 8'h05);
        end

        chk("final_queue_empty", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prog_load_ctrl.md
PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, giving the instruction-memory word-address width (2^ADDR_W words).
REQ-002 SHALL have parameter START_BYTE, default 8'hFE, marking the start of a program.
REQ-003 SHALL have parameter END_BYTE, default 8'hFF, marking the end of a program.
REQ-004 SHALL have parameter ESC_BYTE, default 8'hFD, meaning the next byte is literal data.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 byte_valid_i  input  1  serial byte present.
REQ-008 byte_data_i  input  8  serial byte.
REQ-009 byte_ready_o  output  1  byte accepted when valid&ready at a clock edge.
REQ-010 imem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-011 imem_waddr_o  output  ADDR_W  word address of the write.
REQ-012 imem_wdata_o  output  32  instruction word to write.
REQ-013 cpu_hold_o  output  1  holds the CPU in reset while loading.
REQ-014 load_done_o  output  1  one-cycle pulse on successful completion.
REQ-015 load_err_o  output  1  sticky error flag.
REQ-016 word_count_o  output  ADDR_W+1  words written by the current or last load.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, ESC, CSUM and DONE.
REQ-018 IDLE: SHALL discard all bytes except START_BYTE; START_BYTE -> LOAD, clearing the byte lane, word address, word_count_o and load_err_o.
REQ-019 LOAD: SHALL handle bytes as follows.
- Data byte: packed into the current word.
- ESC_BYTE: -> ESC.
- START_BYTE: restarts the load as in REQ-018.
- END_BYTE: -> CSUM when PROG_LOAD_CSUM_EN is defined, else -> DONE.
REQ-020 ESC: SHALL pack the next accepted byte as data, whatever its value, then return to LOAD.
REQ-021 Byte packing SHALL be big-endian: the 1st byte goes to bits [31:24] and the 4th to bits [7:0].
REQ-022 When the 4th byte is accepted at edge t, SHALL assert imem_we_o for exactly one cycle after t, with the registered address and word; word_count_o increments in the same cycle.
REQ-023 On END_BYTE with 1-3 bytes pending, SHALL write the partial word with the unfilled low bytes zero, in the cycle after END is accepted.
REQ-024 Overflow: a data byte arriving after 2^ADDR_W words are written SHALL set load_err_o, is never written, and address SHALL NOT wrap; further data SHALL be discarded until END_BYTE.
REQ-025 DONE: SHALL last one cycle, pulse load_done_o unless load_err_o is set, then -> IDLE.
REQ-026 byte_ready_o SHALL be 1 in IDLE, LOAD, ESC and CSUM, and 0 in DONE.
REQ-027 cpu_hold_o SHALL be 1 in every state other than IDLE.
REQ-028 END_BYTE with zero data bytes SHALL complete with word_count_o=0 and no writes.

Reset
REQ-029 Asserting reset SHALL force IDLE and clear the following within the same cycle, including mid-load:
- all outputs, word_count_o, load_err_o;
- the byte lane and the checksum accumulator.
- Partially loaded memory contents SHALL be left as they are.

Configuration
REQ-030 With PROG_LOAD_CSUM_EN defined, the controller SHALL keep a running XOR of all packed data bytes.
- After END_BYTE, the next accepted byte is the checksum (CSUM state).
- A mismatch sets load_err_o; the FSM then -> DONE.
REQ-031 Without PROG_LOAD_CSUM_EN, SHALL contain no CSUM state and no accumulator, and END_BYTE -> DONE directly.

Structure
REQ-032 Package prog_load_pkg SHALL hold the FSM state enum and the default START/END/ESC byte constants.
REQ-033 The byte-to-word packer (lane counter, shift register, zero-pad) SHALL be sub-module prog_load_packer; all other logic is in prog_load_ctrl.

Verification
REQ-034 FE,00,00,00,13,FF -> one write addr 0 data 32'h00000013; load_done_o pulses; word_count_o=1; cpu_hold_o falls one cycle after DONE.
REQ-035 FE,FD,FF,FD,FE,01,02,FF -> write addr 0 data 32'hFFFE0102.
REQ-036 FE,AA,BB,FF -> write 32'hAABB0000 at addr 0 in the cycle after END.
REQ-037 ADDR_W=2, FE, 17 data bytes, FF -> 4 writes (addr 0-3), load_err_o=1, no load_done_o, word_count_o=4.
REQ-038 Reset asserted after FE,11,22 -> outputs 0 and IDLE immediately; a subsequent FE,01,02,03,04,FF writes 32'h01020304 at addr 0.
REQ-039 With PROG_LOAD_CSUM_EN: FE,01,02,03,04,FF,04 -> done with no error; a checksum byte of 05 -> load_err_o=1.
